game_seq: RTL and testbench

GAME_SEQ -- requirements
Module: game_seq

---
 rtl/game_defs.sv | 24 ++
 rtl/edge_det.sv | 28 ++
 rtl/game_seq.sv | 173 +++++++++++++++++
 tb/tb_game_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_defs.sv
// Shared definitions for the game sequencer.
// Holds the FSM state encoding (also driven onto the debug/sound
// "state" port) and the default timing/score constants.
package game_defs;

  // Encodings 5-7 are unused and recover to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int DEF_SERVE_FRAMES = 60;  // ticks from SERVE entry to release
  localparam int DEF_POINT_FRAMES = 90;  // ticks spent showing a point
  localparam int DEF_WIN_SCORE    = 9;   // score that ends the match (1..15)

  // 8-bit counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Single-register edge detector.
// Ports:
//   clk     - clock, rising edge
//   i_rst_n - synchronous active-low reset; register loads RST_VAL
//   i_d     - level input, already synchronous to clk
//   o_edge  - one-cycle pulse: rising edge (FALLING=0) or falling edge (FALLING=1)
module edge_det #(
  parameter bit RST_VAL = 1'b0,
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_edge
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!i_rst_n) r_q <= RST_VAL;
    else          r_q <= i_d;
  end

  // Combinational against the previous sample so the pulse lines up with
  // the cycle in which the new level is first seen.
  assign o_edge = FALLING ? (r_q & ~i_d) : (i_d & ~r_q);

endmodule

// File: rtl/game_seq.sv
// Match sequencer for a two-player ball game.
// Walks IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER), keeps the scores,
// and drives the ball controls. Time is measured in VGA frame ticks.
// Ports:
//   clk_25MHz        - system clock, rising edge
//   reset            - synchronous active-low reset
//   v_sync           - active-low vertical sync; each falling edge is a tick
//   serve_btn        - start / restart request (level, synchronous)
//   LftCollision     - ball passed the left boundary (level)
//   RgtCollision     - ball passed the right boundary (level)
//   ball_run         - ball motion enable (high only in PLAY)
//   ball_center      - one-cycle pulse recentring the ball
//   serve_dir        - 0 serve toward left, 1 serve toward right
//   Lftscore/Rgtscore- binary scores
//   LftWin/RgtWin    - match-won flags, valid in OVER
//   state            - current FSM state encoding
//
// Handshake note: there is no valid/ready pairing here; every input acts
// only on its edge, and every output is a register updated together with
// the state register, so outputs always agree with "state" in the same cycle.
module game_seq
  import game_defs::*;
#(
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       v_sync,
  input  logic       serve_btn,
  input  logic       LftCollision,
  input  logic       RgtCollision,
  output logic       ball_run,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [3:0] Lftscore,
  output logic [3:0] Rgtscore,
  output logic       LftWin,
  output logic       RgtWin,
  output logic [2:0] state
);

  localparam logic [8:0] SERVE_F9 = 9'(SERVE_FRAMES);
  localparam logic [8:0] POINT_F9 = 9'(POINT_FRAMES);
  localparam logic [3:0] WIN4     = 4'(WIN_SCORE);

  logic w_tick, w_btn, w_lc, w_rc;

  // v_sync register resets to 1 so no tick is seen straight out of reset.
  edge_det #(.RST_VAL(1'b1), .FALLING(1'b1)) u_vs_edge (
    .clk(clk_25MHz), .i_rst_n(reset), .i_d(v_sync), .o_edge(w_tick)
  );
  edge_det #(.RST_VAL(1'b0), .FALLING(1'b0)) u_btn_edge (
    .clk(clk_25MHz), .i_rst_n(reset), .i_d(serve_btn), .o_edge(w_btn)
  );
  edge_det #(.RST_VAL(1'b0), .FALLING(1'b0)) u_lc_edge (
    .clk(clk_25MHz), .i_rst_n(reset), .i_d(LftCollision), .o_edge(w_lc)
  );
  edge_det #(.RST_VAL(1'b0), .FALLING(1'b0)) u_rc_edge (
    .clk(clk_25MHz), .i_rst_n(reset), .i_d(RgtCollision), .o_edge(w_rc)
  );

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt;
  logic [3:0] r_lft, r_rgt, w_lft_nxt, w_rgt_nxt;
  logic       r_dir, w_dir_nxt;
  logic       r_lwin, r_rwin, w_lwin_nxt, w_rwin_nxt;
  logic       r_center, w_center_nxt;
  logic       r_run;

  // True when the tick being seen now is the N-th since the state was entered.
  logic w_serve_done, w_point_done, w_any_win;
  assign w_serve_done = w_tick && (({1'b0, r_cnt} + 9'd1) >= SERVE_F9);
  assign w_point_done = w_tick && (({1'b0, r_cnt} + 9'd1) >= POINT_F9);
  assign w_any_win    = (r_lft == WIN4) || (r_rgt == WIN4);

  always_comb begin
    w_state_nxt  = r_state;
    w_lft_nxt    = r_lft;
    w_rgt_nxt    = r_rgt;
    w_dir_nxt    = r_dir;
    w_lwin_nxt   = r_lwin;
    w_rwin_nxt   = r_rwin;
    w_center_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_btn) begin
          w_lft_nxt    = 4'd0;
          w_rgt_nxt    = 4'd0;
          w_center_nxt = 1'b1;
          w_state_nxt  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (w_serve_done) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_lc && w_rc) begin
          // Ambiguous rally: nobody scores, serve again.
          w_center_nxt = 1'b1;
          w_state_nxt  = ST_SERVE;
        end else if (w_lc) begin
          if (!w_any_win) w_rgt_nxt = r_rgt + 4'd1;
          w_dir_nxt   = 1'b0;
          w_state_nxt = ST_POINT;
        end else if (w_rc) begin
          if (!w_any_win) w_lft_nxt = r_lft + 4'd1;
          w_dir_nxt   = 1'b1;
          w_state_nxt = ST_POINT;
        end
      end
      ST_POINT: begin
        if (w_any_win) begin
          w_lwin_nxt  = (r_lft == WIN4);
          w_rwin_nxt  = (r_rgt == WIN4);
          w_state_nxt = ST_OVER;
        end else if (w_point_done) begin
          w_center_nxt = 1'b1;
          w_state_nxt  = ST_SERVE;
        end
      end
      ST_OVER: begin
        if (w_btn) begin
          w_lft_nxt    = 4'd0;
          w_rgt_nxt    = 4'd0;
          w_lwin_nxt   = 1'b0;
          w_rwin_nxt   = 1'b0;
          w_center_nxt = 1'b1;
          w_state_nxt  = ST_SERVE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_lft    <= 4'd0;
      r_rgt    <= 4'd0;
      r_dir    <= 1'b1;
      r_lwin   <= 1'b0;
      r_rwin   <= 1'b0;
      r_center <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      // Frame counter restarts on every state change, else counts ticks.
      if (w_state_nxt != r_state) r_cnt <= 8'd0;
      else if (w_tick)            r_cnt <= sat_inc8(r_cnt);
      r_lft    <= w_lft_nxt;
      r_rgt    <= w_rgt_nxt;
      r_dir    <= w_dir_nxt;
      r_lwin   <= w_lwin_nxt;
      r_rwin   <= w_rwin_nxt;
      r_center <= w_center_nxt;
      // Decoded from the next state so it changes on the same edge as state.
      r_run    <= (w_state_nxt == ST_PLAY);
    end
  end

  assign state       = r_state;
  assign ball_run    = r_run;
  assign ball_center = r_center;
  assign serve_dir   = r_dir;
  assign Lftscore    = r_lft;
  assign Rgtscore    = r_rgt;
  assign LftWin      = r_lwin;
  assign RgtWin      = r_rwin;

endmodule

// File: tb/tb_game_seq.sv
// Bench for game_seq: directed match walk-through plus randomized rallies,
// checked against a rules-level model of the match (scores, winner,
// serve direction and game phase).
module tb_game_seq;

  localparam int SERVE_F = 60;
  localparam int POINT_F = 90;
  localparam int WIN     = 9;

  // Phase codes as published on the state port.
  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_PLAY  = 2;
  localparam int P_POINT = 3;
  localparam int P_OVER  = 4;

  logic       clk_25MHz;
  logic       reset;
  logic       v_sync;
  logic       serve_btn;
  logic       LftCollision;
  logic       RgtCollision;
  logic       ball_run;
  logic       ball_center;
  logic       serve_dir;
  logic [3:0] Lftscore;
  logic [3:0] Rgtscore;
  logic       LftWin;
  logic       RgtWin;
  logic [2:0] state;

  game_seq #(
    .SERVE_FRAMES(SERVE_F),
    .POINT_FRAMES(POINT_F),
    .WIN_SCORE(WIN)
  ) dut (
    .clk_25MHz(clk_25MHz),
    .reset(reset),
    .v_sync(v_sync),
    .serve_btn(serve_btn),
    .LftCollision(LftCollision),
    .RgtCollision(RgtCollision),
    .ball_run(ball_run),
    .ball_center(ball_center),
    .serve_dir(serve_dir),
    .Lftscore(Lftscore),
    .Rgtscore(Rgtscore),
    .LftWin(LftWin),
    .RgtWin(RgtWin),
    .state(state)
  );

  // ---------------- clock ----------------
  initial begin
    clk_25MHz = 1'b0;
    forever #20 clk_25MHz = ~clk_25MHz;
  end

  // ---------------- reference model ----------------
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_phase;
  int   m_lft, m_rgt;
  logic m_dir, m_lwin, m_rwin;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_lft   = 0;
    m_rgt   = 0;
    m_dir   = 1'b1;
    m_lwin  = 1'b0;
    m_rwin  = 1'b0;
  endtask

  task automatic model_new_match();
    m_lft   = 0;
    m_rgt   = 0;
    m_lwin  = 1'b0;
    m_rwin  = 1'b0;
    m_phase = P_SERVE;
  endtask

  // kind 0: ball went out on the left -> right player scores, serve left.
  // kind 1: ball went out on the right -> left player scores, serve right.
  task automatic model_collide(input int kind);
    if (m_lft != WIN && m_rgt != WIN) begin
      if (kind == 0) m_rgt++;
      else           m_lft++;
    end
    m_dir   = (kind == 0) ? 1'b0 : 1'b1;
    m_phase = P_POINT;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},    8'(state),    8'(m_phase));
    chk({tag, ".lftscore"}, 8'(Lftscore), 8'(m_lft));
    chk({tag, ".rgtscore"}, 8'(Rgtscore), 8'(m_rgt));
    chk({tag, ".lftwin"},   8'(LftWin),   8'(m_lwin));
    chk({tag, ".rgtwin"},   8'(RgtWin),   8'(m_rwin));
    chk({tag, ".ball_run"}, 8'(ball_run), (m_phase == P_PLAY) ? 8'd1 : 8'd0);
    chk({tag, ".serve_dir"},8'(serve_dir),8'(m_dir));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_25MHz);
    #1;
  endtask

  task automatic frame_tick();
    v_sync = 1'b0;
    cyc(1);
    v_sync = 1'b1;
    cyc(2);
  endtask

  // From a fresh SERVE entry through ball release; ball_run must rise on
  // exactly the edge that samples the last tick.
  task automatic serve_phase();
    if ($urandom_range(0, 1) == 1) begin
      serve_btn = 1'b1;
      cyc(1);
      serve_btn = 1'b0;
      cyc(1);
      check_all("serve_btn_ignored");
    end
    repeat (SERVE_F - 1) frame_tick();
    check_all("serve_hold");
    v_sync = 1'b0;
    cyc(1);
    v_sync = 1'b1;
    m_phase = P_PLAY;
    check_all("serve_release");
    cyc(2);
  endtask

  // kind 2: both boundaries in the same cycle.
  task automatic rally(input int kind, input int hold);
    if (kind == 2) begin
      LftCollision = 1'b1;
      RgtCollision = 1'b1;
      cyc(1);
      m_phase = P_SERVE;
      check_all("both");
      chk("both.center", 8'(ball_center), 8'd1);
    end else begin
      if (kind == 0) LftCollision = 1'b1;
      else           RgtCollision = 1'b1;
      cyc(1);
      model_collide(kind);
      check_all("collide");
      chk("collide.center", 8'(ball_center), 8'd0);
      if (m_lft == WIN || m_rgt == WIN) begin
        cyc(1);
        m_phase = P_OVER;
        m_lwin  = (m_lft == WIN);
        m_rwin  = (m_rgt == WIN);
        check_all("over");
      end
    end
    cyc(hold);
    LftCollision = 1'b0;
    RgtCollision = 1'b0;
    cyc(1);
    check_all("after_hold");
  endtask

  // From POINT entry (no win) through the recentre pulse into SERVE.
  task automatic finish_point();
    serve_btn    = 1'b1;
    LftCollision = ($urandom_range(0, 1) == 1);
    RgtCollision = ($urandom_range(0, 1) == 1);
    cyc(1);
    serve_btn    = 1'b0;
    LftCollision = 1'b0;
    RgtCollision = 1'b0;
    cyc(1);
    check_all("point_ignored");
    repeat (POINT_F - 1) frame_tick();
    check_all("point_hold");
    v_sync = 1'b0;
    cyc(1);
    v_sync  = 1'b1;
    m_phase = P_SERVE;
    check_all("point_release");
    chk("point_release.center", 8'(ball_center), 8'd1);
    cyc(1);
    chk("center_one_cycle", 8'(ball_center), 8'd0);
    cyc(1);
  endtask

  task automatic press_serve_start(input string tag);
    serve_btn = 1'b1;
    cyc(1);
    model_new_match();
    check_all(tag);
    chk({tag, ".center"}, 8'(ball_center), 8'd1);
    serve_btn = 1'b0;
    cyc(1);
    chk({tag, ".center_low"}, 8'(ball_center), 8'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  kind;
    bit  hit;
    reset        = 1'b0;
    v_sync       = 1'b1;
    serve_btn    = 1'b0;
    LftCollision = 1'b0;
    RgtCollision = 1'b0;
    model_reset();
    cyc(3);
    reset = 1'b1;
    check_all("reset");
    chk("reset.center", 8'(ball_center), 8'd0);

    // Collisions and ticks in IDLE do nothing.
    RgtCollision = 1'b1;
    cyc(2);
    RgtCollision = 1'b0;
    frame_tick();
    check_all("idle_ignored");

    // Start, then serve release timing.
    press_serve_start("start");
    serve_phase();

    // Right boundary held 10 cycles: exactly one point for the left player.
    rally(1, 10);
    finish_point();

    // Simultaneous boundaries: no point, re-serve.
    serve_phase();
    rally(2, 3);

    // Random rallies until the left player sits on 8, right kept below 8.
    for (int r = 0; r < 60; r++) begin
      if (m_lft >= WIN - 1) break;
      serve_phase();
      kind = (r >= 40) ? 1 : int'($urandom_range(0, 2));
      if (kind == 0 && m_rgt >= WIN - 2) kind = 1;
      rally(kind, int'($urandom_range(1, 12)));
      if (kind != 2) finish_point();
    end
    chk("left_reaches_8", 8'(Lftscore), 8'(WIN - 1));

    // Winning point.
    serve_phase();
    rally(1, 2);
    chk("win.lftscore", 8'(Lftscore), 8'(WIN));
    chk("win.lftwin", 8'(LftWin), 8'd1);

    // Collisions in OVER leave everything alone.
    LftCollision = 1'b1;
    cyc(2);
    RgtCollision = 1'b1;
    cyc(2);
    LftCollision = 1'b0;
    RgtCollision = 1'b0;
    frame_tick();
    check_all("over_hold");

    // Restart from OVER.
    press_serve_start("restart");

    // Random rallies until the right player reaches 5, then reset mid-POINT.
    hit = 1'b0;
    for (int r = 0; r < 40; r++) begin
      serve_phase();
      kind = (r >= 25) ? 0 : int'($urandom_range(0, 2));
      if (kind == 1 && m_lft >= WIN - 2) kind = 0;
      rally(kind, int'($urandom_range(1, 12)));
      if (kind == 0 && m_rgt == 5) begin
        hit = 1'b1;
        break;
      end
      if (kind != 2) finish_point();
    end
    chk("reached_rgt_5", 8'(hit), 8'd1);
    frame_tick();
    frame_tick();
    check_all("mid_point");
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    model_reset();
    check_all("reset_mid_point");
    chk("reset_mid_point.center", 8'(ball_center), 8'd0);

    // Back to normal operation after reset.
    frame_tick();
    check_all("post_reset_idle");
    press_serve_start("post_reset_start");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
